// File: rtl/simple_frame_fifo_pkg.sv
// Shared constants for the frame-commit buffer and its status register block.
package simple_frame_fifo_pkg;

  localparam int DROP_CNT_W = 16;

endpackage

// File: rtl/simple_sdp_ram.sv
// Simple dual-port RAM: one write port, one registered read port (1-cycle read latency).
// No backpressure; read data holds its value while rd_en_i is low.
module simple_sdp_ram #(
  parameter int WIDTH = 129,
  parameter int DEPTH = 64
) (
  input  logic                     clk,
  input  logic                     wr_en_i,
  input  logic [$clog2(DEPTH)-1:0] wr_addr_i,
  input  logic [WIDTH-1:0]         wr_data_i,
  input  logic                     rd_en_i,
  input  logic [$clog2(DEPTH)-1:0] rd_addr_i,
  output logic [WIDTH-1:0]         rd_data_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] rd_data_q;

  always_ff @(posedge clk) begin
    if (wr_en_i) begin
      mem_q[wr_addr_i] <= wr_data_i;
    end
    if (rd_en_i) begin
      rd_data_q <= mem_q[rd_addr_i];
    end
  end

  assign rd_data_o = rd_data_q;

endmodule

// File: rtl/simple_frame_fifo.sv
// Frame-commit FIFO: frames become readable only once complete; first word out 2 cycles after last in.
// Input has no backpressure (frames that do not fit are dropped whole); output is valid/ready.
module simple_frame_fifo
  import simple_frame_fifo_pkg::*;
#(
  parameter int DATA_WIDTH = 128,
  parameter int DEPTH      = 64
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       din_vld,
  input  logic                       din_last,
  input  logic [DATA_WIDTH-1:0]      din,
  output logic                       dout_valid,
  input  logic                       dout_ready,
  output logic                       dout_last,
  output logic [DATA_WIDTH-1:0]      dout,
  output logic [$clog2(DEPTH):0]     level,
  output logic [DROP_CNT_W-1:0]      drop_cnt
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;
  localparam int EW = DATA_WIDTH + 1;

  typedef enum logic {
    ST_ACCEPT = 1'b0,
    ST_DROP   = 1'b1
  } wr_state_e;

  wr_state_e             state_q, state_d;
  logic [PW-1:0]         wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]         wr_cmt_q, wr_cmt_d;
  logic [PW-1:0]         rd_ptr_q, rd_ptr_d;
  logic [DROP_CNT_W-1:0] drop_cnt_q, drop_cnt_d;
  logic                  ram_vld_q, ram_vld_d;
  logic                  out_vld_q, out_vld_d;
  logic [EW-1:0]         out_dat_q, out_dat_d;

  logic                  full;
  logic                  drop_inc;
  logic                  ram_we;
  logic                  ram_re;
  logic                  out_free;
  logic [EW-1:0]         ram_rdata;

  simple_sdp_ram #(
    .WIDTH (EW),
    .DEPTH (DEPTH)
  ) u_ram (
    .clk       (clk),
    .wr_en_i   (ram_we),
    .wr_addr_i (wr_ptr_q[AW-1:0]),
    .wr_data_i ({din_last, din}),
    .rd_en_i   (ram_re),
    .rd_addr_i (rd_ptr_q[AW-1:0]),
    .rd_data_o (ram_rdata)
  );

  // Speculative words count against capacity, so a frame never overwrites unread data.
  assign full = ((wr_ptr_q - rd_ptr_q) == PW'(DEPTH));

  always_comb begin
    state_d    = state_q;
    wr_ptr_d   = wr_ptr_q;
    wr_cmt_d   = wr_cmt_q;
    drop_cnt_d = drop_cnt_q;
    ram_we     = 1'b0;
    drop_inc   = 1'b0;
    case (state_q)
      ST_ACCEPT: begin
        if (din_vld) begin
          if (!full) begin
            ram_we   = 1'b1;
            wr_ptr_d = wr_ptr_q + PW'(1);
            if (din_last) begin
              wr_cmt_d = wr_ptr_q + PW'(1);
            end
          end else begin
            wr_ptr_d = wr_cmt_q;
            if (din_last) begin
              drop_inc = 1'b1;
            end else begin
              state_d = ST_DROP;
            end
          end
        end
      end
      ST_DROP: begin
        if (din_vld && din_last) begin
          drop_inc = 1'b1;
          state_d  = ST_ACCEPT;
        end
      end
      default: state_d = ST_ACCEPT;
    endcase
    if (drop_inc && (drop_cnt_q != {DROP_CNT_W{1'b1}})) begin
      drop_cnt_d = drop_cnt_q + DROP_CNT_W'(1);
    end
  end

  // Two-stage read pipe: RAM read register feeds the output register; the RAM
  // register doubles as the skid slot when the consumer stalls.
  always_comb begin
    out_free  = !out_vld_q || dout_ready;
    ram_re    = (rd_ptr_q != wr_cmt_q) && (!ram_vld_q || out_free);
    rd_ptr_d  = ram_re ? (rd_ptr_q + PW'(1)) : rd_ptr_q;
    ram_vld_d = ram_re || (ram_vld_q && !out_free);
    out_vld_d = out_free ? ram_vld_q : out_vld_q;
    out_dat_d = (out_free && ram_vld_q) ? ram_rdata : out_dat_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_ACCEPT;
      wr_ptr_q   <= '0;
      wr_cmt_q   <= '0;
      rd_ptr_q   <= '0;
      drop_cnt_q <= '0;
      ram_vld_q  <= 1'b0;
      out_vld_q  <= 1'b0;
      out_dat_q  <= '0;
    end else begin
      state_q    <= state_d;
      wr_ptr_q   <= wr_ptr_d;
      wr_cmt_q   <= wr_cmt_d;
      rd_ptr_q   <= rd_ptr_d;
      drop_cnt_q <= drop_cnt_d;
      ram_vld_q  <= ram_vld_d;
      out_vld_q  <= out_vld_d;
      out_dat_q  <= out_dat_d;
    end
  end

  assign dout_valid = out_vld_q;
  assign dout_last  = out_dat_q[EW-1];
  assign dout       = out_dat_q[DATA_WIDTH-1:0];
  assign drop_cnt   = drop_cnt_q;
  assign level      = (wr_cmt_q - rd_ptr_q) + PW'(ram_vld_q) + PW'(out_vld_q);

endmodule

// File: tb/tb_simple_frame_fifo.sv
// Scoreboard bench for simple_frame_fifo with a small DEPTH so full/drop cases are cheap to reach.
module tb_simple_frame_fifo;

  localparam int DW    = 32;
  localparam int DEPTH = 8;
  localparam int LW    = $clog2(DEPTH) + 1;

  logic          clk = 1'b0;
  logic          rst;
  logic          din_vld;
  logic          din_last;
  logic [DW-1:0] din;
  logic          dout_valid;
  logic          dout_ready;
  logic          dout_last;
  logic [DW-1:0] dout;
  logic [LW-1:0] level;
  logic [15:0]   drop_cnt;

  simple_frame_fifo #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) dut (
    .clk        (clk),
    .rst        (rst),
    .din_vld    (din_vld),
    .din_last   (din_last),
    .din        (din),
    .dout_valid (dout_valid),
    .dout_ready (dout_ready),
    .dout_last  (dout_last),
    .dout       (dout),
    .level      (level),
    .drop_cnt   (drop_cnt)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  logic [DW:0] exp_q[$];
  int pushed = 0;
  int popped = 0;
  bit gen_done;
  bit mon_stall = 1'b0;
  logic [DW:0] prev_word;
  logic [DW:0] mon_w;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, req);
    end
  endtask

  // Monitor: pops the expected stream on every handshake and checks stall stability.
  always @(negedge clk) begin
    if (rst) begin
      mon_stall = 1'b0;
    end else begin
      if (mon_stall) begin
        check("stall_valid", 32'(dout_valid), 32'd1);
        check("stall_dout", 32'(dout), 32'(prev_word[DW-1:0]));
        check("stall_last", 32'(dout_last), 32'(prev_word[DW]));
      end
      if (dout_valid && dout_ready) begin
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_word: got %0h want none", dout);
        end else begin
          mon_w = exp_q.pop_front();
          check("out_data", 32'(dout), 32'(mon_w[DW-1:0]));
          check("out_last", 32'(dout_last), 32'(mon_w[DW]));
          popped++;
        end
      end
      mon_stall = dout_valid && !dout_ready;
      prev_word = {dout_last, dout};
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_word(input logic [DW-1:0] d, input bit l);
    din_vld  = 1'b1;
    din      = d;
    din_last = l;
    tick();
    din_vld  = 1'b0;
    din_last = 1'b0;
  endtask

  task automatic send_frame(input int len, input bit accepted, input bit seq);
    logic [DW-1:0] d;
    for (int i = 0; i < len; i++) begin
      d = seq ? DW'(i + 1) : DW'($urandom);
      if (accepted) begin
        exp_q.push_back({(i == len - 1), d});
        pushed++;
      end
      send_word(d, (i == len - 1));
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    exp_q.delete();
    pushed = 0;
    popped = 0;
    tick();
    tick();
    rst = 1'b0;
    tick();
  endtask

  task automatic drain(input string name);
    int n;
    n = 0;
    dout_ready = 1'b1;
    while (exp_q.size() != 0 && n < 300) begin
      tick();
      n++;
    end
    if (exp_q.size() != 0) begin
      total++;
      bad++;
      $display("FAIL %s_drain_timeout: got %0d words left want 0", name, exp_q.size());
    end
    tick();
    tick();
    check({name, "_level_empty"}, 32'(level), 32'd0);
    check({name, "_valid_empty"}, 32'(dout_valid), 32'd0);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst        = 1'b1;
    din_vld    = 1'b0;
    din_last   = 1'b0;
    din        = '0;
    dout_ready = 1'b0;
    gen_done   = 1'b0;
    do_reset();

    check("rst_valid", 32'(dout_valid), 32'd0);
    check("rst_last", 32'(dout_last), 32'd0);
    check("rst_dout", 32'(dout), 32'd0);
    check("rst_level", 32'(level), 32'd0);
    check("rst_drop", 32'(drop_cnt), 32'd0);

    // Single 4-word frame: first word visible two edges after the last input word.
    dout_ready = 1'b1;
    send_frame(4, 1'b1, 1'b1);
    check("lat_n0_valid", 32'(dout_valid), 32'd0);
    tick();
    check("lat_n1_valid", 32'(dout_valid), 32'd0);
    for (int i = 0; i < 4; i++) begin
      tick();
      check("seq_valid", 32'(dout_valid), 32'd1);
      check("seq_dout", 32'(dout), 32'(i + 1));
      check("seq_last", 32'(dout_last), 32'(i == 3));
    end
    drain("single");

    // 6-word frame held, then a 5-word frame that overflows on its last word.
    do_reset();
    dout_ready = 1'b0;
    send_frame(6, 1'b1, 1'b0);
    send_frame(5, 1'b0, 1'b0);
    tick();
    tick();
    check("ovf_drop", 32'(drop_cnt), 32'd1);
    check("ovf_level", 32'(level), 32'd6);
    drain("ovf");

    // Back-to-back 3-word frames, random consumer, only sent when space is guaranteed.
    do_reset();
    gen_done = 1'b0;
    fork
      begin
        for (int f = 0; f < 60; f++) begin
          int n;
          n = 0;
          while ((pushed - popped) + 3 > DEPTH && n < 500) begin
            tick();
            n++;
          end
          if (n >= 500) begin
            total++;
            bad++;
            $display("FAIL rand_space_timeout: got %0d outstanding want <= %0d", pushed - popped, DEPTH - 3);
          end
          if ($urandom_range(0, 3) == 0) tick();
          send_frame(3, 1'b1, 1'b0);
          check("rand_level", 32'(level), 32'(pushed - popped));
        end
        gen_done = 1'b1;
      end
      begin
        while (!gen_done) begin
          tick();
          dout_ready = 1'($urandom_range(0, 1));
        end
      end
    join
    check("rand_drop", 32'(drop_cnt), 32'd0);
    drain("rand");

    // Exactly DEPTH words fit; a 1-word frame right behind it does not.
    do_reset();
    dout_ready = 1'b0;
    send_frame(DEPTH, 1'b1, 1'b0);
    send_frame(1, 1'b0, 1'b0);
    tick();
    check("exact_drop", 32'(drop_cnt), 32'd1);
    check("exact_level", 32'(level), 32'(DEPTH));
    drain("exact");

    // Reset during an output stall with a partial frame in progress.
    dout_ready = 1'b0;
    send_frame(3, 1'b1, 1'b0);
    tick();
    tick();
    tick();
    check("pre_rst_valid", 32'(dout_valid), 32'd1);
    send_word(DW'($urandom), 1'b0);
    send_word(DW'($urandom), 1'b0);
    rst = 1'b1;
    exp_q.delete();
    pushed = 0;
    popped = 0;
    #1;
    check("arst_valid", 32'(dout_valid), 32'd0);
    check("arst_last", 32'(dout_last), 32'd0);
    check("arst_dout", 32'(dout), 32'd0);
    check("arst_level", 32'(level), 32'd0);
    check("arst_drop", 32'(drop_cnt), 32'd0);
    tick();
    check("arst_valid_hold", 32'(dout_valid), 32'd0);
    rst = 1'b0;
    tick();
    dout_ready = 1'b1;
    send_frame(2, 1'b1, 1'b0);
    drain("post_rst");
    check("post_rst_drop", 32'(drop_cnt), 32'd0);

    // Fill completely, then drop enough single-word frames to saturate the counter.
    do_reset();
    dout_ready = 1'b0;
    send_frame(DEPTH, 1'b1, 1'b0);
    tick();
    tick();
    tick();
    send_frame(2, 1'b1, 1'b0);
    check("sat_fill_level", 32'(level), 32'(DEPTH + 2));
    for (int i = 0; i < 65534; i++) begin
      send_word(DW'(i), 1'b1);
    end
    check("sat_fffe", 32'(drop_cnt), 32'hFFFE);
    for (int i = 0; i < 3; i++) begin
      send_word(DW'(i), 1'b1);
    end
    check("sat_ffff", 32'(drop_cnt), 32'hFFFF);
    check("sat_level", 32'(level), 32'(DEPTH + 2));
    drain("sat");
    check("sat_hold", 32'(drop_cnt), 32'hFFFF);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
